// File: rtl/logic_seq_pkg.sv
// rtl/logic_seq_pkg.sv - opcodes, FSM states and opcode decode for logic_req_sequencer
package logic_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } seq_state_t;

    function automatic logic op_supported(input logic [2:0] op);
`ifdef LOGIC_SEQ_EXT_OPS_EN
        return (op[2] == 1'b0);
`else
        return (op[2:1] == 2'b00);
`endif
    endfunction

endpackage

// File: rtl/logic_req_fifo.sv
// rtl/logic_req_fifo.sv - request FIFO holding {opcode, A, B}; push is dropped when full
module logic_req_fifo #(
    parameter int W     = 67,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/logic_req_sequencer.sv
// rtl/logic_req_sequencer.sv - queues logic-op requests, drives logic_unit, returns results.
// LOGIC_SEQ_EXT_OPS_EN adds locally computed XOR/NOR.
module logic_req_sequencer
    import logic_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_opcode,
    input  logic [WIDTH-1:0]         req_a,
    input  logic [WIDTH-1:0]         req_b,
    output logic [2:0]               lu_opcode,
    output logic [WIDTH-1:0]         lu_a,
    output logic [WIDTH-1:0]         lu_b,
    input  logic [WIDTH-1:0]         lu_out,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     resp_err,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int DW = 2*WIDTH + 3;

    seq_state_t       state_q, state_d;
    logic [2:0]       lu_op_q, lu_op_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d, lu_b_q, lu_b_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    logic [DW-1:0]    fifo_rdata;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [WIDTH-1:0] issue_result;

    logic_req_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (req_valid),
        .wdata_i ({req_opcode, req_a, req_b}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending)
    );

    assign req_ready  = !fifo_full;
    assign lu_opcode  = lu_op_q;
    assign lu_a       = lu_a_q;
    assign lu_b       = lu_b_q;
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

    // Unsupported opcodes never let lu_out through, so resp_data reads 0 with resp_err.
    always_comb begin
        issue_result = '0;
        case (lu_op_q)
            OP_AND, OP_OR: issue_result = lu_out;
`ifdef LOGIC_SEQ_EXT_OPS_EN
            OP_XOR:        issue_result = lu_a_q ^ lu_b_q;
            OP_NOR:        issue_result = ~(lu_a_q | lu_b_q);
`endif
            default:       issue_result = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        lu_op_d     = lu_op_q;
        lu_a_d      = lu_a_q;
        lu_b_d      = lu_b_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    {lu_op_d, lu_a_d, lu_b_d} = fifo_rdata;
                    fifo_pop = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                resp_data_d = issue_result;
                resp_err_d  = !op_supported(lu_op_q);
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    if (!fifo_empty) begin
                        {lu_op_d, lu_a_d, lu_b_d} = fifo_rdata;
                        fifo_pop = 1'b1;
                        state_d  = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lu_op_q     <= '0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lu_op_q     <= lu_op_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_logic_req_sequencer.sv
// tb/tb_logic_req_sequencer.sv - directed bench for logic_req_sequencer with a logic_unit model
module tb_logic_req_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_opcode;
    logic [31:0] req_a, req_b;
    logic [2:0]  lu_opcode;
    logic [31:0] lu_a, lu_b, lu_out;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [2:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Opcodes the logic unit does not decode return a garbage value that must never surface.
    assign lu_out = (lu_opcode == 3'b000) ? (lu_a & lu_b) :
                    (lu_opcode == 3'b001) ? (lu_a | lu_b) : 32'hDEAD_BEEF;

    logic_req_sequencer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .lu_opcode  (lu_opcode),
        .lu_a       (lu_a),
        .lu_b       (lu_b),
        .lu_out     (lu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .pending    (pending)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit done = 1'b0;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!done) begin
                if (req_ready) done = 1'b1;
                tick();
            end
        end
        req_valid = 1'b0;
        if (!done) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_resp(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!got) begin
                if (resp_valid) got = 1'b1;
                else tick();
            end
        end
        if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic collect(input string name, input int n, input bit chk_gap);
        int got  = 0;
        int last = -1;
        resp_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (got < n) begin
                if (resp_valid) begin
                    check($sformatf("%s_data%0d", name, got), 64'(resp_data), 64'(exp_q.pop_front()));
                    if (chk_gap && last >= 0) check($sformatf("%s_gap%0d", name, got), 64'(c - last), 64'd2);
                    last = c;
                    got++;
                end
                tick();
            end
        end
        if (got < n) check({name, "_timeout"}, 64'(got), 64'(n));
    endtask

    initial begin
        logic [31:0] hold_data, hold_a, hold_b;
        logic [2:0]  hold_op;
        logic        hold_err;
        bit          stable;

        vecs[0] = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        vecs[1] = '{3'b001, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
`ifdef LOGIC_SEQ_EXT_OPS_EN
        vecs[2] = '{3'b010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
        vecs[3] = '{3'b011, 32'h1234_5678, 32'h0000_FFFF, 32'hEDCB_0000, 1'b0};
`else
        vecs[2] = '{3'b010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1};
        vecs[3] = '{3'b011, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_0000, 1'b1};
`endif
        vecs[4] = '{3'b101, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0000_0000, 1'b1};
        vecs[5] = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[6] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7] = '{3'b001, 32'h0000_0000, 32'h8000_0001, 32'h8000_0001, 1'b0};
        vecs[8] = '{3'b100, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0000, 1'b1};

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 3'b000;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;

        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_pending",    64'(pending),    64'd0);
        check("rst_lu_opcode",  64'(lu_opcode),  64'd0);
        check("rst_lu_a",       64'(lu_a),       64'd0);
        check("rst_lu_b",       64'(lu_b),       64'd0);
        check("rst_resp_data",  64'(resp_data),  64'd0);
        check("rst_resp_err",   64'(resp_err),   64'd0);

        // Single AND with exact latency
        req_opcode = 3'b000;
        req_a      = 32'hF0F0_F0F0;
        req_b      = 32'hFF00_FF00;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        check("lat_t0_pending", 64'(pending),    64'd1);
        check("lat_t0_valid",   64'(resp_valid), 64'd0);
        tick();
        check("lat_t1_lu_op",   64'(lu_opcode),  64'd0);
        check("lat_t1_lu_a",    64'(lu_a),       64'hF0F0_F0F0);
        check("lat_t1_lu_b",    64'(lu_b),       64'hFF00_FF00);
        check("lat_t1_valid",   64'(resp_valid), 64'd0);
        tick();
        check("lat_t2_valid",   64'(resp_valid), 64'd1);
        check("lat_t2_data",    64'(resp_data),  64'hF000_F000);
        check("lat_t2_err",     64'(resp_err),   64'd0);
        tick();
        check("lat_t3_valid",   64'(resp_valid), 64'd0);

        // Table of single operations
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_resp($sformatf("vec%0d", i));
            check($sformatf("vec%0d_data", i), 64'(resp_data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i),  64'(resp_err),  64'(vecs[i].exp_err));
            tick();
        end

        // Fill to full, try an extra push, then drain back-to-back
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(3'b000, 32'h1000_0000 + 32'(i), 32'hFFFF_FFFF);
            exp_q.push_back(32'h1000_0000 + 32'(i));
        end
        check("fill_pending", 64'(pending),   64'd4);
        check("fill_ready",   64'(req_ready), 64'd0);
        req_opcode = 3'b001;
        req_a      = 32'hBAD0_0000;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        check("fill_nobypass", 64'(pending), 64'd4);
        collect("fill", 5, 1'b1);

        // Backpressure holds response and operands
        resp_ready = 1'b0;
        push(3'b001, 32'h1234_0000, 32'h0000_5678);
        wait_resp("bp");
        hold_data = resp_data;
        hold_err  = resp_err;
        hold_op   = lu_opcode;
        hold_a    = lu_a;
        hold_b    = lu_b;
        stable    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!resp_valid || resp_data !== hold_data || resp_err !== hold_err ||
                lu_opcode !== hold_op || lu_a !== hold_a || lu_b !== hold_b) stable = 1'b0;
        end
        check("bp_stable", 64'(stable),    64'd1);
        check("bp_data",   64'(resp_data), 64'h1234_5678);
        check("bp_lu_a",   64'(lu_a),      64'h1234_0000);
        resp_ready = 1'b1;
        tick();
        check("bp_release", 64'(resp_valid), 64'd0);

        // Reset during ISSUE with three entries queued
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(3'b001, 32'h0000_0100 * 32'(i + 1), 32'h0000_0001);
        check("rmid_pend_pre", 64'(pending), 64'd3);
        resp_ready = 1'b1;
        req_opcode = 3'b000;
        req_a      = 32'h5555_5555;
        req_b      = 32'hFFFF_FFFF;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rmid_pend_issue", 64'(pending),    64'd3);
        check("rmid_in_issue",   64'(resp_valid), 64'd0);
        reset_n    = 1'b0;
        resp_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rmid_pending", 64'(pending),    64'd0);
        check("rmid_valid",   64'(resp_valid), 64'd0);
        check("rmid_lu_op",   64'(lu_opcode),  64'd0);
        check("rmid_lu_a",    64'(lu_a),       64'd0);
        check("rmid_lu_b",    64'(lu_b),       64'd0);
        check("rmid_ready",   64'(req_ready),  64'd1);
        resp_ready = 1'b1;
        push(3'b000, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        wait_resp("rmid_after");
        check("rmid_after_data", 64'(resp_data), 64'h0505_0505);
        check("rmid_after_err",  64'(resp_err),  64'd0);
        tick();

        // Push and pop in the same cycle with two queued
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(3'b001, 32'h0000_0A00 + 32'(i), 32'h0000_0000);
        check("pp_pend_pre", 64'(pending),    64'd2);
        check("pp_valid",    64'(resp_valid), 64'd1);
        check("pp_first",    64'(resp_data),  64'h0000_0A00);
        resp_ready = 1'b1;
        req_opcode = 3'b001;
        req_a      = 32'h0000_0A03;
        req_b      = 32'h0000_0000;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        check("pp_pend_same", 64'(pending), 64'd2);
        exp_q.push_back(32'h0000_0A01);
        exp_q.push_back(32'h0000_0A02);
        exp_q.push_back(32'h0000_0A03);
        collect("pp", 3, 1'b1);
        check("pp_drained", 64'(pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
